// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its user.
// The user (master) drives enable and the PWM line; the capture block (slave) returns measurements.
interface pwm_capture_if #(
  parameter int BW = 8
);
  logic          en;
  logic          pwm_in;
  logic [BW-1:0] duty;
  logic [BW-1:0] period;
  logic          valid;
  logic          stuck;

  modport master (
    output en,
    output pwm_in,
    input  duty,
    input  period,
    input  valid,
    input  stuck
  );

  modport slave (
    input  en,
    input  pwm_in,
    output duty,
    output period,
    output valid,
    output stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of each full PWM cycle, flags stuck inputs by timeout.
// Optional glitch filter on the synchronized input is enabled with `define PWM_CAPTURE_GLITCH_EN.
module pwm_capture #(
  parameter int BW         = 8,
  parameter int GLITCH_LEN = 3
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);

  localparam logic [BW-1:0] CNT_MAX = {BW{1'b1}};

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t        state;
  logic          sync_p0, sync_p1;
  logic          s, s_d;
  logic          rise;
  logic [BW-1:0] period_cnt, high_cnt;
  logic [BW-1:0] duty_q, period_q;
  logic          valid_q, stuck_q;

  if (GLITCH_LEN < 1) begin : g_bad_glitch_len
    $error("pwm_capture: GLITCH_LEN must be at least 1");
  end

  // A timed-out period is reported as fully high or fully low, by the level it is stuck at.
  function automatic logic [BW-1:0] timeout_duty(input logic lvl);
    return lvl ? CNT_MAX : '0;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.pwm_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage s: registered (optionally filtered) level
`ifdef PWM_CAPTURE_GLITCH_EN
  localparam int GW = $clog2(GLITCH_LEN + 1);
  logic [GW-1:0] glitch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= 1'b0;
      glitch_cnt <= '0;
    end else if (sync_p1 == s) begin
      glitch_cnt <= '0;
    end else if (glitch_cnt == GW'(GLITCH_LEN - 1)) begin
      s          <= sync_p1;
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) s <= 1'b0;
    else     s <= sync_p1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign rise = s & ~s_d;

  // Measurement FSM: a rise closes the running period and opens the next one at count 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.en) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state      <= MEASURE;
              period_cnt <= BW'(1);
              high_cnt   <= BW'(1);
            end
          end
          MEASURE: begin
            if (rise) begin
              duty_q     <= high_cnt;
              period_q   <= period_cnt;
              valid_q    <= 1'b1;
              stuck_q    <= 1'b0;
              period_cnt <= BW'(1);
              high_cnt   <= BW'(1);
            end else if (period_cnt == CNT_MAX) begin
              duty_q     <= timeout_duty(s);
              period_q   <= CNT_MAX;
              valid_q    <= 1'b1;
              stuck_q    <= 1'b1;
              state      <= IDLE;
              period_cnt <= '0;
              high_cnt   <= '0;
            end else begin
              period_cnt <= period_cnt + 1'b1;
              high_cnt   <= high_cnt + BW'(s);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.duty   = duty_q;
  assign bus.period = period_q;
  assign bus.valid  = valid_q;
  assign bus.stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: each driven PWM period that will be closed by a later rise
// (or by timeout) pushes its expected duty/period/stuck; the monitor pops one entry per valid.
module tb_pwm_capture;

  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.BW(BW)) bus ();

  pwm_capture #(.BW(BW), .GLITCH_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int period;
    int stuck;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input int d, input int p, input int st);
    exp_t e;
    e.duty   = d;
    e.period = p;
    e.stuck  = st;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    bus.pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_period(input int h, input int p);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  // 100/255 waveform with a 2-cycle low glitch 30 cycles into the high phase.
  task automatic glitch_period();
    hold(1'b1, 30);
    hold(1'b0, 2);
    hold(1'b1, 68);
    hold(1'b0, 155);
  endtask

  task automatic push_glitch_period();
`ifdef PWM_CAPTURE_GLITCH_EN
    push(100, 255, 0);
`else
    push(30, 32, 0);
    push(68, 223, 0);
`endif
  endtask

  // Monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      if (exp_q.size() == 0) begin
        chk("valid_unexpected", 32'(bus.valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("duty",   int'(bus.duty),   e.duty);
        chk("period", int'(bus.period), e.period);
        chk("stuck",  int'(bus.stuck),  e.stuck);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty",   int'(bus.duty),   0);
    chk("rst_period", int'(bus.period), 0);
    chk("rst_valid",  int'(bus.valid),  0);
    chk("rst_stuck",  int'(bus.stuck),  0);
    rst    = 1'b0;
    bus.en = 1'b1;
    hold(1'b0, 10);

    // Steady 100/255: four periods, the first three closed by the following rise.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) push(100, 255, 0);
      drive_period(100, 255);
    end

    // Stuck high: the rise closes period four, then timeout reports full duty.
    push(100, 255, 0);
    push(255, 255, 1);
    hold(1'b1, 400);
    chk("stuck_high_level", int'(bus.stuck), 1);
    hold(1'b1, 200);
    hold(1'b0, 20);

    // Normal periods clear stuck; then a lone pulse followed by a stuck-low timeout.
    push(50, 120, 0);
    drive_period(50, 120);
    push(50, 120, 0);
    drive_period(50, 120);
    push(0, 255, 1);
    hold(1'b1, 10);
    hold(1'b0, 400);

    // Enable dropped mid-period: that period is discarded and outputs hold.
    push(40, 120, 0);
    drive_period(40, 120);
    hold(1'b1, 40);
    hold(1'b0, 20);
    bus.en = 1'b0;
    hold(1'b0, 25);
    chk("en_hold_duty",   int'(bus.duty),   40);
    chk("en_hold_period", int'(bus.period), 120);
    chk("en_hold_valid",  int'(bus.valid),  0);
    chk("en_hold_stuck",  int'(bus.stuck),  0);
    hold(1'b0, 25);
    bus.en = 1'b1;
    hold(1'b0, 10);
    push(40, 120, 0);
    drive_period(40, 120);
    push(40, 120, 0);
    drive_period(40, 120);

    // Reset mid-period: outputs clear, the period in progress is discarded.
    hold(1'b1, 40);
    hold(1'b0, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_duty",   int'(bus.duty),   0);
    chk("midrst_period", int'(bus.period), 0);
    chk("midrst_valid",  int'(bus.valid),  0);
    chk("midrst_stuck",  int'(bus.stuck),  0);
    hold(1'b0, 59);
    push(40, 120, 0);
    drive_period(40, 120);

    // Glitches inside the high phase.
    push_glitch_period();
    glitch_period();
    push_glitch_period();
    glitch_period();
    hold(1'b1, 5);
    hold(1'b0, 30);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
